// File: rtl/ball_motion.sv
// Ball (smiley) position/velocity owner: latches collision strobes during a frame,
// applies reflection and gravity once per frame, and publishes the integer top-left pixel.
module ball_motion #(
    parameter int INITIAL_X       = 280,
    parameter int INITIAL_Y       = 185,
    parameter int INITIAL_X_SPEED = 40,
    parameter int INITIAL_Y_SPEED = 20,
    parameter int Y_ACCEL         = 1,
    parameter int MAX_Y_SPEED     = 230,
    parameter int FRAC_BITS       = 6
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        pause,
    input  logic        reset_level,
    input  logic        collisionSmileyBorderTop,
    input  logic        collisionSmileyBorderLeft,
    input  logic        collisionSmileyBorderRight,
    input  logic        collisionSmileyFlipper,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY
);

    // state   | meaning
    // HOLD    | frozen, waiting for pause to drop; flags cleared every cycle
    // RUN     | collecting collision strobes until startOfFrame
    // UPD_SPD | apply reflections and gravity to speed
    // UPD_POS | integrate speed into position
    typedef enum logic [1:0] {HOLD = 2'd0, RUN = 2'd1, UPD_SPD = 2'd2, UPD_POS = 2'd3} state_t;

    localparam logic signed [31:0] POS_X0  = 32'(INITIAL_X * (1 << FRAC_BITS));
    localparam logic signed [31:0] POS_Y0  = 32'(INITIAL_Y * (1 << FRAC_BITS));
    localparam logic signed [31:0] SPD_X0  = 32'(INITIAL_X_SPEED);
    localparam logic signed [31:0] SPD_Y0  = 32'(INITIAL_Y_SPEED);
    localparam logic signed [31:0] ACCEL   = 32'(Y_ACCEL);
    localparam logic signed [31:0] MAX_SPD = 32'(MAX_Y_SPEED);

    state_t             state_q, state_d;
    logic signed [31:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic signed [31:0] spd_x_q, spd_x_d, spd_y_q, spd_y_d;
    logic        [3:0]  flags_q, flags_d;  // {top, left, right, flipper}
    logic        [10:0] top_x_q, top_y_q;

    logic signed [31:0] abs_x, abs_y, spd_y_ref, spd_y_acc;

    always_comb begin
        abs_x     = spd_x_q[31] ? -spd_x_q : spd_x_q;
        abs_y     = spd_y_q[31] ? -spd_y_q : spd_y_q;
        spd_y_ref = spd_y_q;
        if (flags_q[0])
            spd_y_ref = -abs_y;
        else if (flags_q[3])
            spd_y_ref = abs_y;
        spd_y_acc = spd_y_ref + ACCEL;
        if (spd_y_acc > MAX_SPD)
            spd_y_acc = MAX_SPD;
        else if (spd_y_acc < -MAX_SPD)
            spd_y_acc = -MAX_SPD;
    end

    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        spd_x_d = spd_x_q;
        spd_y_d = spd_y_q;
        flags_d = flags_q | {collisionSmileyBorderTop, collisionSmileyBorderLeft,
                             collisionSmileyBorderRight, collisionSmileyFlipper};
        case (state_q)
            HOLD: begin
                flags_d = '0;
                if (!pause) state_d = RUN;
            end
            RUN: begin
                if (pause)             state_d = HOLD;
                else if (startOfFrame) state_d = UPD_SPD;
            end
            UPD_SPD: begin
                case (flags_q[2:1])
                    2'b10:   spd_x_d = abs_x;
                    2'b01:   spd_x_d = -abs_x;
                    2'b11:   spd_x_d = -spd_x_q;
                    default: spd_x_d = spd_x_q;
                endcase
                spd_y_d = spd_y_acc;
                flags_d = '0;
                state_d = UPD_POS;
            end
            UPD_POS: begin
                pos_x_d = pos_x_q + spd_x_q;
                pos_y_d = pos_y_q + spd_y_q;
                state_d = RUN;
            end
            default: state_d = HOLD;
        endcase
        // Re-serve overrides anything in flight, including a half-done update.
        if (reset_level) begin
            state_d = HOLD;
            pos_x_d = POS_X0;
            pos_y_d = POS_Y0;
            spd_x_d = SPD_X0;
            spd_y_d = SPD_Y0;
            flags_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= HOLD;
            pos_x_q <= POS_X0;
            pos_y_q <= POS_Y0;
            spd_x_q <= SPD_X0;
            spd_y_q <= SPD_Y0;
            flags_q <= '0;
            top_x_q <= 11'(INITIAL_X);
            top_y_q <= 11'(INITIAL_Y);
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            spd_x_q <= spd_x_d;
            spd_y_q <= spd_y_d;
            flags_q <= flags_d;
            top_x_q <= 11'(pos_x_q >>> FRAC_BITS);
            top_y_q <= 11'(pos_y_q >>> FRAC_BITS);
        end
    end

    assign topLeftX = top_x_q;
    assign topLeftY = top_y_q;

endmodule
